serial_digit_adder: RTL
=======================

# serial_digit_adder

Multi-cycle WIDTH-bit adder that processes operands two bits per clock, least-significant digit first. Each cycle a 2-bit digit adder with carry-in combines the current operand digits, and a carry register links consecutive digits. The block sits in front of the 2-bit adder datapath. Upstream hands it WIDTH-bit operands over a valid/ready handshake, and downstream takes the WIDTH-bit sum and final carry over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits. Must be even and ≥ 2; any other value is an elaboration error.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream presents operands a and b.
- in_ready  output  1  block can accept operands; equals (state == IDLE) && !rst.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- out_valid  output  1  sum and carry_out are final.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result (a + b) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.

## Operation
- **Internal state:**
  - FSM state: IDLE, RUN or DONE.
  - Operand shift registers ra and rb, each WIDTH bits.
  - Carry register c.
  - Digit counter cnt, $clog2(WIDTH/2)+1 bits.
  - Sum shift register rs, WIDTH bits, driving sum.
- **IDLE:**
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: ra ← a, rb ← b, c ← 0, cnt ← 0, state → RUN.
- **RUN (one digit per cycle):**
  - Digit sum {d_cout, d} = ra[1:0] + rb[1:0] + c.
  - rs ← {d, rs[WIDTH-1:2]}, so the sum fills from the top down.
  - ra ← ra >> 2, rb ← rb >> 2, c ← d_cout, cnt ← cnt + 1.
  - When cnt == WIDTH/2 − 1 this edge processes the last digit and sets state → DONE.
- **DONE:**
  - out_valid = 1, sum = rs, carry_out = c.
  - Values are held stable for as long as out_ready = 0.
  - On out_ready = 1: state → IDLE.
- **Reset values (rst sampled high):**
  - state = IDLE, rs = 0, c = 0, cnt = 0, ra = rb = 0.
  - Outputs: sum = 0, carry_out = 0, out_valid = 0, in_ready = 0 while rst is high and 1 on the first cycle after.
- **Boundary conditions:**
  - in_valid outside IDLE is ignored because in_ready = 0; upstream holds its operands.
  - Changes on a or b after the accept edge have no effect.
  - out_ready with out_valid low has no effect.
  - Reset during RUN or DONE aborts the operation: no out_valid and no partial result.
  - No operand is accepted in the DONE→IDLE transfer cycle; acceptance starts in IDLE.
  - Wrap-around: overflow beyond WIDTH bits appears only on carry_out; sum wraps mod 2^WIDTH.
  - The carry chains across all digits, e.g. 0xFF + 0x01 propagates through every digit.

## Timing
- **Accept:** edge E0, with state IDLE and in_valid = 1.
- **Digits:** processed on edges E1 … E(WIDTH/2); E(WIDTH/2) sets state = DONE.
- **Latency:** out_valid rises after E(WIDTH/2), i.e. WIDTH/2 cycles after accept. For WIDTH = 8 that is 4 cycles; for WIDTH = 2 it is 1 cycle.
- **Result transfer:** on the edge where out_valid && out_ready; state is IDLE after that edge.
- **Throughput:** minimum spacing between accepts is WIDTH/2 + 2 cycles.
- **Output timing:** all outputs are registered or decoded from registered state. in_ready also depends combinationally on rst. No combinational path from in_valid or out_ready to any output.

## Structure
- **Shared package serial_add_pkg:**
  - State encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - DIGIT_W = 2.
- **Sub-module digit_adder2** (purely combinational):
  - Ports: x[1:0], y[1:0], cin, s[1:0], cout.
  - Built from two chained 1-bit full adders.
  - Instantiated once; fed from ra[1:0], rb[1:0] and c.
- All sequencing (FSM, counter, shift registers, handshakes) lives in serial_digit_adder.

## Test plan
- WIDTH = 8, a = 0x5A, b = 0x3C, out_ready = 1 → out_valid 4 cycles after accept, sum = 0x96, carry_out = 0, state IDLE on the next cycle.
- a = 0xFF, b = 0x01 → sum = 0x00, carry_out = 1 (full ripple); then a = 0x80, b = 0x80 → sum = 0x00, carry_out = 1.
- Backpressure: a = 0x12, b = 0x34, out_ready low for 5 cycles after out_valid → sum = 0x46 and carry_out = 0 held stable, in_ready = 0 throughout; out_ready high → in_ready = 1 on the next cycle.
- Reset after 2 RUN cycles of 0xAA + 0x55 → after the rst edge: out_valid = 0, sum = 0, carry_out = 0, in_ready = 1; then 0x01 + 0x02 → sum = 0x03.
- Operand isolation: accept 0x10 + 0x20, then change a/b and pulse in_valid during RUN → sum = 0x30, and no second accept until IDLE.
- WIDTH = 2: a = 3, b = 3 → out_valid 1 cycle after accept, sum = 2'b10, carry_out = 1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the two-bits-per-cycle serial adder: digit width
// and FSM state encoding.
package serial_add_pkg;

    localparam int DIGIT_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/digit_adder2.sv
// Purely combinational 2-bit digit adder built from two chained full adders.
module digit_adder2
    import serial_add_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
            assign s[gi]       = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout = carry[DIGIT_W];

endmodule

// File: rtl/serial_digit_adder.sv
// WIDTH-bit adder that consumes operands one 2-bit digit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_digit_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = $clog2(NDIG) + 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_digit_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_cout;
    logic [WIDTH+1:0]   rs_ext;

    digit_adder2 u_digit (
        .x    (ra_q[DIGIT_W-1:0]),
        .y    (rb_q[DIGIT_W-1:0]),
        .cin  (c_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // New digit enters at the top; shifting the widened vector keeps WIDTH == 2 legal.
    assign rs_ext = {dig_s, rs_q};

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rs_d  = rs_ext[WIDTH+1:2];
                ra_d  = ra_q >> DIGIT_W;
                rb_d  = rb_q >> DIGIT_W;
                c_d   = dig_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign sum       = rs_q;
    assign carry_out = c_q;

endmodule
